// File: rtl/alu_pg_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_pg_stage
//  Purpose  : Registered operand / propagate-generate stage feeding the 4-bit
//             look-ahead carry sub-blocks. Computes per-bit propagate (p),
//             generate (g) and half-sum (h) with 74181-style function-select
//             gating, then presents them through a two-entry skid buffer so
//             full throughput is kept while the carry stage stalls.
//  Ports    : clk, rst_n (async, active low)
//             in_valid / in_ready   : upstream handshake (in_ready registered)
//             A, B [WIDTH]          : operands
//             S [4]                 : function select
//             Ci_inverse, M_inverse : active-low carry-in / mode, forwarded
//             out_valid / out_ready : downstream handshake
//             p, g, h [WIDTH]       : propagate / generate / half-sum vectors
//             Ci_inverse_o, M_inverse_o : forwarded carry-in and mode
//             op_count [16]         : completed output transfers (wrapping)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_pg_stage #(
  parameter int WIDTH = 16  // multiple of 4: one nibble per carry sub-block
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       S,
  input  logic             Ci_inverse,
  input  logic             M_inverse,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic             Ci_inverse_o,
  output logic             M_inverse_o,
  output logic [15:0]      op_count
);

  // Entry layout: {p, g, h, Ci_inverse, M_inverse}
  localparam int c_ENTRY_W = 3 * WIDTH + 2;
  // Cleared entry: vectors zero, active-low controls at their inactive level.
  localparam logic [c_ENTRY_W-1:0] c_RESET_ENTRY = {{(3 * WIDTH){1'b0}}, 2'b11};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic [c_ENTRY_W-1:0]   r_main;
  logic [c_ENTRY_W-1:0]   r_skid;
  logic [15:0]            r_op_count;

  logic [WIDTH-1:0]       w_p;
  logic [WIDTH-1:0]       w_g;
  logic [WIDTH-1:0]       w_h;
  logic [c_ENTRY_W-1:0]   w_entry;
  logic                   w_in_xfer;
  logic                   w_out_xfer;

  // Per-bit function-select gating, evaluated ahead of the capture register.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_g[i] = (A[i] & B[i] & S[3]) | (A[i] & ~B[i] & S[2]);
    assign w_p[i] = A[i] | (B[i] & S[0]) | (~B[i] & S[1]);
    assign w_h[i] = w_p[i] & ~w_g[i];
  end

  // S only steers the gating above; it is not carried further downstream.
  assign w_entry    = {w_p, w_g, w_h, Ci_inverse, M_inverse};
  assign w_in_xfer  = in_valid & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main      <= c_RESET_ENTRY;
      r_skid      <= c_RESET_ENTRY;
      r_op_count  <= 16'd0;
    end else begin
      if (w_out_xfer) begin
        r_op_count <= r_op_count + 16'd1;
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            r_main      <= w_entry;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main <= w_entry;
          end else if (w_in_xfer) begin
            // Consumer stalled: park the newcomer so M stays stable.
            r_skid     <= w_entry;
            r_in_ready <= 1'b0;
            r_state    <= ST_FULL;
          end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so no input can arrive this cycle.
          if (w_out_xfer) begin
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= ST_EMPTY;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign {p, g, h, Ci_inverse_o, M_inverse_o} = r_main;
  assign op_count  = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_pg_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_pg_stage
//  Purpose  : Self-checking bench for alu_pg_stage: fixed vector table,
//             skid/stall and async-reset sequences, random streaming against
//             a scoreboard fed by a behavioural p/g/h model, op_count wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pg_stage;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] A = '0;
  logic [WIDTH-1:0] B = '0;
  logic [3:0]       S = '0;
  logic             Ci_inverse = 1'b1;
  logic             M_inverse = 1'b1;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] h;
  logic             Ci_inverse_o;
  logic             M_inverse_o;
  logic [15:0]      op_count;

  alu_pg_stage #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .A            (A),
    .B            (B),
    .S            (S),
    .Ci_inverse   (Ci_inverse),
    .M_inverse    (M_inverse),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .p            (p),
    .g            (g),
    .h            (h),
    .Ci_inverse_o (Ci_inverse_o),
    .M_inverse_o  (M_inverse_o),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a, b;
    logic [3:0]  s;
    logic        ci, mi;
    logic [15:0] eg, ep, eh;
  } vec_t;

  typedef struct {
    logic [15:0] p, g, h;
    logic        ci, mi;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  exp_t mon_e;
  exp_t x1, x2;
  int   total = 0;
  int   bad = 0;
  logic [63:0] prev_out;
  bit   prev_stall = 0;

  // Bit-level truth of the selector: with A=1 the bit generates when the
  // selector picked for B's value says so and always propagates; with A=0
  // it never generates and propagates when the selector for B says so.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] s, input logic ci, input logic mi);
    exp_t r;
    logic gb, pb;
    for (int i = 0; i < 16; i++) begin
      if (a[i]) begin
        gb = b[i] ? s[3] : s[2];
        pb = 1'b1;
      end else begin
        gb = 1'b0;
        pb = b[i] ? s[0] : s[1];
      end
      r.g[i] = gb;
      r.p[i] = pb;
      r.h[i] = pb & ~gb;
    end
    r.ci = ci;
    r.mi = mi;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({out_valid, p, g, h, Ci_inverse_o, M_inverse_o});
  endfunction

  function automatic logic [63:0] pack_exp(input exp_t e);
    return 64'({1'b1, e.p, e.g, e.h, e.ci, e.mi});
  endfunction

  task automatic rand_in();
    A          = 16'($urandom);
    B          = 16'($urandom);
    S          = 4'($urandom);
    Ci_inverse = 1'($urandom);
    M_inverse  = 1'($urandom);
  endtask

  task automatic set_in(input exp_t dummy, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] s, input logic ci, input logic mi);
    A = a; B = b; S = s; Ci_inverse = ci; M_inverse = mi;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: inputs change at posedge+1, so negedge sees a settled cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) check("hold_stable", outs(), prev_out);
      if (in_valid && in_ready) sb.push_back(model(A, B, S, Ci_inverse, M_inverse));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(1), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          check("fifo_order", outs(), pack_exp(mon_e));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = outs();
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    //          a         b         s        ci    mi    eg        ep        eh
    vecs[0] = '{16'h00FF, 16'h0F0F, 4'b1001, 1'b1, 1'b1, 16'h000F, 16'h0FFF, 16'h0FF0};
    vecs[1] = '{16'h00FF, 16'h0F0F, 4'b0110, 1'b0, 1'b1, 16'h00F0, 16'hF0FF, 16'hF00F};
    vecs[2] = '{16'h1234, 16'hFFFF, 4'b0000, 1'b1, 1'b0, 16'h0000, 16'h1234, 16'h1234};
    vecs[3] = '{16'hA5A5, 16'h0F0F, 4'b1111, 1'b0, 1'b0, 16'hA5A5, 16'hFFFF, 16'h5A5A};
    vecs[4] = '{16'hFFFF, 16'h00FF, 4'b0100, 1'b1, 1'b1, 16'hFF00, 16'hFFFF, 16'h00FF};
    vecs[5] = '{16'hF0F0, 16'hFF00, 4'b1000, 1'b0, 1'b1, 16'hF000, 16'hF0F0, 16'h00F0};

    // ---------------- reset values ----------------
    do_reset();
    check("rst_out", outs(), 64'({1'b0, 48'h0, 2'b11}));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_op_count", 64'(op_count), 64'(0));
    @(posedge clk); #1;

    // ---------------- vector table ----------------
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_in(mon_e, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].ci, vecs[i].mi);
      in_valid = 1'b1;
      check($sformatf("vec%0d_pre_valid", i), 64'(out_valid), 64'(0));
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("vec%0d", i),
            64'({out_valid, vecs[i].eg, vecs[i].ep, vecs[i].eh, Ci_inverse_o, M_inverse_o}),
            64'({1'b1, g, p, h, vecs[i].ci, vecs[i].mi}));
      check($sformatf("vec%0d_ctrl", i), 64'({Ci_inverse_o, M_inverse_o}),
            64'({vecs[i].ci, vecs[i].mi}));
      @(posedge clk); #1;
    end
    check("vec_op_count", 64'(op_count), 64'(6));

    // ---------------- stall / skid ----------------
    out_ready = 1'b0;
    x1 = model(16'h1234, 16'h5678, 4'b1001, 1'b1, 1'b1);
    x2 = model(16'hCAFE, 16'h0F0F, 4'b0110, 1'b0, 1'b0);
    set_in(mon_e, 16'h1234, 16'h5678, 4'b1001, 1'b1, 1'b1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("skid_x1_ready", 64'(in_ready), 64'(1));
    set_in(mon_e, 16'hCAFE, 16'h0F0F, 4'b0110, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("skid_full_ready", 64'(in_ready), 64'(0));
    check("skid_full_out", outs(), pack_exp(x1));
    set_in(mon_e, 16'hFFFF, 16'hFFFF, 4'b1111, 1'b0, 1'b0);  // must be ignored
    repeat (3) @(posedge clk);
    #1;
    check("skid_hold_out", outs(), pack_exp(x1));
    check("skid_hold_ready", 64'(in_ready), 64'(0));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("skid_x2_out", outs(), pack_exp(x2));
    check("skid_ready_back", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    check("skid_drained", 64'(out_valid), 64'(0));
    check("skid_op_count", 64'(op_count), 64'(8));

    // ---------------- async reset while FULL ----------------
    out_ready = 1'b0;
    rand_in(); in_valid = 1'b1;
    @(posedge clk); #1;
    rand_in();
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("arst_pre_full", 64'(in_ready), 64'(0));
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("arst_out", outs(), 64'({1'b0, 48'h0, 2'b11}));
    check("arst_in_ready", 64'(in_ready), 64'(1));
    check("arst_op_count", 64'(op_count), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_after_ready", 64'({in_ready, out_valid}), 64'(2'b10));
    check("arst_after_count", 64'(op_count), 64'(0));

    // ---------------- random stalls ----------------
    for (int i = 0; i < 400; i++) begin
      rand_in();
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rand_drain", 64'({out_valid, 32'(sb.size())}), 64'(0));

    // ---------------- streaming 100 ops ----------------
    do_reset();
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_in();
      in_valid = 1'b1;
      check($sformatf("stream_valid%0d", i), 64'(out_valid), 64'(i > 0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("stream_last_valid", 64'(out_valid), 64'(1));
    @(posedge clk); #1;
    check("stream_op_count", 64'({out_valid, op_count}), 64'({1'b0, 16'd100}));

    // ---------------- op_count wrap ----------------
    do_reset();
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      rand_in();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("wrap_ffff", 64'(op_count), 64'(16'hFFFF));
    rand_in();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("wrap_zero", 64'(op_count), 64'(0));
    check("wrap_drain", 64'({out_valid, 32'(sb.size())}), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
